// File: rtl/sdram_arbiter.sv
// sdram_arbiter -- two-port, slot-based SDRAM access arbiter.
//
// Decisions are taken only on clk edges where the sync strobe is high. Each
// such edge completes the slot in flight and then grants the next one. A
// granted request completes exactly one slot later. Port 0 has fixed priority.
// The port being acked is not eligible on that same edge, so both ports
// alternate when both hold their request.
//
// Optional feature: define SDRAM_ARB_REFRESH_GAP_EN to enable a run counter.
// After MAX_RUN consecutive granted slots, the next slot is forced idle so
// that downstream logic gets a refresh opportunity.
//
// Ports
//   clk, resetn           system clock, asynchronous active-low reset
//   sync                  one-clk slot strobe (start of each slot)
//   pN_req/we/ds/addr/wdata   requester N command (N = 0, 1)
//   pN_ack                one-clk completion pulse for requester N
//   pN_rdata              read data for requester N, valid from the ack cycle
//   ram_we/oe/ds/addr/din SDRAM command, held constant for the whole slot
//   ram_dout              SDRAM read data, sampled on the completing sync edge
//
// State | meaning
// IDLE  | no slot in flight (current slot is idle)
// BUSY  | a granted slot is in flight, owner/owner_we identify it

module sdram_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int MAX_RUN = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sync,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_ds,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_wdata,
    output logic              p0_ack,
    output logic [15:0]       p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_ds,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_wdata,
    output logic              p1_ack,
    output logic [15:0]       p1_rdata,

    output logic              ram_we,
    output logic              ram_oe,
    output logic [1:0]        ram_ds,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if (MAX_RUN < 1) begin : g_bad_max_run
        $error("sdram_arbiter: MAX_RUN must be at least 1");
    end

    logic [0:0]        state;
    logic              owner;      // 0 = p0, 1 = p1
    logic              owner_we;

    logic              gnt0;
    logic              gnt1;
    logic              force_idle;
    logic              grant_any;
    logic              sel_we;
    logic [1:0]        sel_ds;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;

`ifdef SDRAM_ARB_REFRESH_GAP_EN
    localparam int RUN_W = $clog2(MAX_RUN + 1);

    logic [RUN_W-1:0] run_cnt;

    assign force_idle = (run_cnt == RUN_W'(MAX_RUN));

    // Counts consecutive granted slots; any idle slot (forced or not) clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_cnt <= '0;
        end else if (sync) begin
            if (grant_any) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end else begin
                run_cnt <= '0;
            end
        end
    end
`else
    assign force_idle = 1'b0;
`endif

    // The owner of the completing slot is excluded on this edge.
    always_comb begin
        gnt0      = p0_req && !((state == ST_BUSY) && (owner == 1'b0));
        gnt1      = p1_req && !((state == ST_BUSY) && (owner == 1'b1)) && !gnt0;
        grant_any = (gnt0 || gnt1) && !force_idle;
        if (gnt0) begin
            sel_we    = p0_we;
            sel_ds    = p0_ds;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end else begin
            sel_we    = p1_we;
            sel_ds    = p1_ds;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            owner_we <= 1'b0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            ram_we   <= 1'b0;
            ram_oe   <= 1'b0;
            ram_ds   <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            // Acks are one-clk pulses; sync pulses are at least 2 clk apart.
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (sync) begin
                if (state == ST_BUSY) begin
                    if (owner == 1'b0) begin
                        p0_ack <= 1'b1;
                        if (!owner_we) p0_rdata <= ram_dout;
                    end else begin
                        p1_ack <= 1'b1;
                        if (!owner_we) p1_rdata <= ram_dout;
                    end
                end
                if (grant_any) begin
                    state    <= ST_BUSY;
                    owner    <= !gnt0;
                    owner_we <= sel_we;
                    ram_we   <= sel_we;
                    ram_oe   <= !sel_we;
                    ram_ds   <= sel_ds;
                    ram_addr <= sel_addr;
                    ram_din  <= sel_wdata;
                end else begin
                    // Idle slot: address and data keep their last values.
                    state  <= ST_IDLE;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    ram_ds <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int ADDR_W = 20;
`ifdef SDRAM_ARB_REFRESH_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic              clk;
    logic              resetn;
    logic              sync;
    logic              p0_req, p0_we, p0_ack;
    logic [1:0]        p0_ds;
    logic [ADDR_W-1:0] p0_addr;
    logic [15:0]       p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_ack;
    logic [1:0]        p1_ds;
    logic [ADDR_W-1:0] p1_addr;
    logic [15:0]       p1_wdata, p1_rdata;
    logic              ram_we, ram_oe;
    logic [1:0]        ram_ds;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din, ram_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int a0, a1;
    int p1_ack_seen;

    sdram_arbiter #(.ADDR_W(ADDR_W), .MAX_RUN(7)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sync     (sync),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_ds    (p0_ds),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_ack   (p0_ack),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_ds    (p1_ds),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_ack   (p1_ack),
        .p1_rdata (p1_rdata),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe),
        .ram_ds   (ram_ds),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (p1_ack) p1_ack_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One sync edge, at least 2 clk after the previous one; returns #1 after it.
    task automatic sync_pulse();
        repeat (2) @(negedge clk);
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; sync = 1'b0; ram_dout = '0;
        p0_req = 0; p0_we = 0; p0_ds = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_ds = 0; p1_addr = '0; p1_wdata = '0;
        p1_ack_seen = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_we",   ram_we,   0);
        chk("rst_ram_oe",   ram_oe,   0);
        chk("rst_ram_ds",   ram_ds,   0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din",  ram_din,  0);
        chk("rst_p0_ack",   p0_ack,   0);
        chk("rst_p1_ack",   p1_ack,   0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        @(negedge clk);
        resetn = 1'b1;

        // p0 write
        p0_req = 1; p0_we = 1; p0_ds = 2'b11; p0_addr = 20'h12345; p0_wdata = 16'hABCD;
        sync_pulse();
        chk("wr_ram_we",   ram_we,   1);
        chk("wr_ram_oe",   ram_oe,   0);
        chk("wr_ram_addr", ram_addr, 20'h12345);
        chk("wr_ram_din",  ram_din,  16'hABCD);
        chk("wr_ram_ds",   ram_ds,   2'b11);
        @(posedge clk);
        #1;
        chk("wr_hold_we",  ram_we,   1);
        chk("wr_early_ack", p0_ack,  0);
        sync_pulse();
        chk("wr_p0_ack",    p0_ack,   1);
        chk("wr_p1_ack",    p1_ack,   0);
        chk("wr_idle_we",   ram_we,   0);
        chk("wr_idle_oe",   ram_oe,   0);
        chk("wr_addr_hold", ram_addr, 20'h12345);
        chk("wr_rdata",     p0_rdata, 0);
        p0_req = 0;
        @(posedge clk);
        #1;
        chk("wr_ack_1clk",  p0_ack,   0);

        // p1 read
        p1_req = 1; p1_we = 0; p1_ds = 2'b01; p1_addr = 20'h00010; ram_dout = 16'h1111;
        sync_pulse();
        chk("rd_ram_oe",   ram_oe,   1);
        chk("rd_ram_we",   ram_we,   0);
        chk("rd_ram_addr", ram_addr, 20'h00010);
        chk("rd_ram_ds",   ram_ds,   2'b01);
        @(posedge clk);
        #1;
        chk("rd_rdata_mid", p1_rdata, 0);
        ram_dout = 16'h5A5A;
        sync_pulse();
        chk("rd_p1_ack",   p1_ack,   1);
        chk("rd_p1_rdata", p1_rdata, 16'h5A5A);
        chk("rd_p0_ack",   p0_ack,   0);
        chk("rd_idle_oe",  ram_oe,   0);
        chk("rd_p0_rdata", p0_rdata, 0);
        p1_req = 0;

        // both ports held: alternation (and forced idle when the gap is enabled)
        p0_req = 1; p0_we = 1; p0_ds = 2'b11; p0_addr = 20'h00100; p0_wdata = 16'h0001;
        p1_req = 1; p1_we = 0; p1_ds = 2'b11; p1_addr = 20'h00200; p1_wdata = 16'h0002;
        a0 = 0; a1 = 0;
        for (int j = 0; j <= 16; j++) begin
            sync_pulse();
            a0 += int'(p0_ack);
            a1 += int'(p1_ack);
            if (j < 16) begin
                if (GAP && (j % 8 == 7)) begin
                    chk($sformatf("alt_idle_we_%0d", j), ram_we, 0);
                    chk($sformatf("alt_idle_oe_%0d", j), ram_oe, 0);
                end else if (j % 2 == 0) begin
                    chk($sformatf("alt_p0_addr_%0d", j), ram_addr, 20'h00100);
                    chk($sformatf("alt_p0_we_%0d", j),   ram_we,   1);
                end else begin
                    chk($sformatf("alt_p1_addr_%0d", j), ram_addr, 20'h00200);
                    chk($sformatf("alt_p1_oe_%0d", j),   ram_oe,   1);
                end
            end
        end
        chk("alt_p0_acks", a0, 8);
        chk("alt_p1_acks", a1, GAP ? 6 : 8);
        p0_req = 0; p1_req = 0;
        sync_pulse();

        // reset during a p0 read slot
        p0_req = 1; p0_we = 0; p0_ds = 2'b11; p0_addr = 20'h00777; ram_dout = 16'h0BAD;
        sync_pulse();
        chk("rr_ram_oe",   ram_oe,   1);
        chk("rr_ram_addr", ram_addr, 20'h00777);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rr_async_oe",   ram_oe,   0);
        chk("rr_async_addr", ram_addr, 0);
        chk("rr_async_ds",   ram_ds,   0);
        chk("rr_p1_rdata",   p1_rdata, 0);
        @(negedge clk);
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        chk("rr_sync_ign_oe",  ram_oe, 0);
        chk("rr_sync_ign_ack", p0_ack, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        sync_pulse();
        chk("rr_no_ack",    p0_ack,   0);
        chk("rr_regrant",   ram_oe,   1);
        chk("rr_reg_addr",  ram_addr, 20'h00777);
        ram_dout = 16'hC0DE;
        sync_pulse();
        chk("rr_ack",       p0_ack,   1);
        chk("rr_rdata",     p0_rdata, 16'hC0DE);
        p0_req = 0;

        // p1 request pulses that never see a sync edge
        p1_ack_seen = 0;
        p1_we = 1; p1_addr = 20'h00ABC;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p1_req = 1;
            @(negedge clk);
            p1_req = 0;
            sync_pulse();
            chk($sformatf("nr_we_%0d", k),  ram_we, 0);
            chk($sformatf("nr_oe_%0d", k),  ram_oe, 0);
            chk($sformatf("nr_ack_%0d", k), p1_ack, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("nr_ack_seen", p1_ack_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
